// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RISC-V load/store size codes,
// the access FSM states and the exception codes reported to WB.
package mem_pkg;

    // Load size/sign codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    // Store size codes share the low funct3 encodings with the loads
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_BUS      = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } exc_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: aligns store data/strobes onto the bus lane,
// extracts and extends load data, and flags misaligned or illegal accesses.
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        addr_lo_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              bad_o
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    logic [LB-1:0]   lane;
    logic [NB-1:0]   byteMask;
    logic [XLEN-1:0] bitMask;
    logic [XLEN-1:0] shifted;
    logic            signBit;
    logic            misalign;
    logic            illegal;

    assign lane = addr_lo_i[LB-1:0];

    // Byte and bit masks covering the access size, anchored at lane 0
    always_comb begin
        byteMask = '0;
        bitMask  = '0;
        for (int i = 0; i < NB; i++) begin
            byteMask[i]       = (i < (1 << funct3_i[1:0]));
            bitMask[8*i +: 8] = {8{byteMask[i]}};
        end
    end

    // Store alignment: strobes and data move up to the addressed lane
    always_comb begin
        wstrb_o = byteMask << lane;
        wdata_o = wdata_i << {lane, 3'b000};
    end

    // Load extraction: bring the addressed lane down, then sign- or zero-extend
    always_comb begin
        shifted = rdata_i >> {lane, 3'b000};
        case (funct3_i)
            F3_LB, F3_LBU: signBit = shifted[7];
            F3_LH, F3_LHU: signBit = shifted[15];
            F3_LW, F3_LWU: signBit = shifted[31];
            default:       signBit = shifted[XLEN-1];
        endcase
        rdata_o = (shifted & bitMask) | ({XLEN{signBit & ~funct3_i[2]}} & ~bitMask);
    end

    // Access legality: natural alignment plus size codes this width cannot do
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr_lo_i[0];
            2'b10:   misalign = |addr_lo_i[1:0];
            default: misalign = |addr_lo_i;
        endcase
        illegal = (funct3_i == F3_BAD) || ((XLEN == 32) && (funct3_i == F3_LD));
        bad_o   = misalign | illegal;
    end

endmodule

// File: rtl/stage_mem_hs.sv
// Pipeline MEM stage talking to a variable-latency data memory over
// req/gnt/rvalid. One access in flight; the pipe stalls until it completes.
module stage_mem_hs
    import mem_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic              in_jump_i,
    input  logic [XLEN-1:0]   in_alu_out_i,
    input  logic              in_mem_en_i,
    input  logic              in_mem_write_i,
    input  logic [2:0]        in_funct3_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [XLEN-1:0]   in_wdata_i,
    output logic              out_valid_o,
    output logic [XLEN-1:0]   out_result_o,
    output logic [XLEN-1:0]   out_rdata_o,
    output logic [1:0]        out_exc_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN/8-1:0] dmem_wstrb_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic              dmem_err_i,
    input  logic [XLEN-1:0]   dmem_rdata_i
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 2);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        alo_q, alo_d;
    logic              write_q, write_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              drop_q, drop_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovalid_q, ovalid_d;
    logic [XLEN-1:0]   oresult_q, oresult_d;
    logic [XLEN-1:0]   ordata_q, ordata_d;
    exc_e              oexc_q, oexc_d;

    logic [2:0]        fmtF3;
    logic [2:0]        fmtAlo;
    logic [NB-1:0]     fmtWstrb;
    logic [XLEN-1:0]   fmtWdata;
    logic [XLEN-1:0]   fmtRdata;
    logic              fmtBad;
    logic [XLEN-1:0]   resultNow;
    logic              timeoutHit;

    // In IDLE the formatter looks at the incoming instruction; afterwards at the latched one
    assign fmtF3  = (state_q == IDLE) ? in_funct3_i    : f3_q;
    assign fmtAlo = (state_q == IDLE) ? in_addr_i[2:0] : alo_q;

    mem_lane_fmt #(.XLEN(XLEN)) uFmt (
        .funct3_i (fmtF3),
        .addr_lo_i(fmtAlo),
        .wdata_i  (in_wdata_i),
        .rdata_i  (dmem_rdata_i),
        .wstrb_o  (fmtWstrb),
        .wdata_o  (fmtWdata),
        .rdata_o  (fmtRdata),
        .bad_o    (fmtBad)
    );

    assign resultNow  = in_jump_i ? XLEN'(in_pc_i + ADDR_W'(4)) : in_alu_out_i;
    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Next-state and output logic for the IDLE -> REQ -> RESP access sequence
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        daddr_d   = daddr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        alo_d     = alo_q;
        write_d   = write_q;
        res_d     = res_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        ovalid_d  = 1'b0;
        oresult_d = oresult_q;
        ordata_d  = ordata_q;
        oexc_d    = oexc_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && !flush_i) begin
                    f3_d    = in_funct3_i;
                    alo_d   = in_addr_i[2:0];
                    write_d = in_mem_write_i;
                    res_d   = resultNow;
                    drop_d  = 1'b0;
                    if (!in_mem_en_i || fmtBad) begin
                        ovalid_d  = 1'b1;
                        oresult_d = resultNow;
                        ordata_d  = '0;
                        oexc_d    = in_mem_en_i ? EXC_MISALIGN : EXC_NONE;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = in_mem_write_i;
                        daddr_d = {in_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
                        wstrb_d = in_mem_write_i ? fmtWstrb : '0;
                        wdata_d = in_mem_write_i ? fmtWdata : '0;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    drop_d  = flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (timeoutHit) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    ovalid_d  = 1'b1;
                    oresult_d = res_q;
                    ordata_d  = '0;
                    oexc_d    = EXC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flush_i)) begin
                        ovalid_d  = 1'b1;
                        oresult_d = res_q;
                        ordata_d  = (write_q || dmem_err_i) ? '0 : fmtRdata;
                        oexc_d    = dmem_err_i ? EXC_BUS : EXC_NONE;
                    end
                end else if (timeoutHit) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flush_i)) begin
                        ovalid_d  = 1'b1;
                        oresult_d = res_q;
                        ordata_d  = '0;
                        oexc_d    = EXC_TIMEOUT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush_i) begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, latched instruction fields and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            daddr_q   <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            alo_q     <= '0;
            write_q   <= 1'b0;
            res_q     <= '0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
            ovalid_q  <= 1'b0;
            oresult_q <= '0;
            ordata_q  <= '0;
            oexc_q    <= EXC_NONE;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            daddr_q   <= daddr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            alo_q     <= alo_d;
            write_q   <= write_d;
            res_q     <= res_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            ovalid_q  <= ovalid_d;
            oresult_q <= oresult_d;
            ordata_q  <= ordata_d;
            oexc_q    <= oexc_d;
        end
    end

    assign in_ready_o   = (state_q == IDLE);
    assign out_valid_o  = ovalid_q;
    assign out_result_o = oresult_q;
    assign out_rdata_o  = ordata_q;
    assign out_exc_o    = oexc_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = daddr_q;
    assign dmem_wstrb_o = wstrb_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_stage_mem_hs.sv
// Self-checking bench for stage_mem_hs: a 64-bit instance (short timeout)
// driven from a vector table with a result scoreboard, hand-written flush and
// reset sequences, and a 32-bit instance for the narrow-width load cases.
module tb_stage_mem_hs;

    logic clk;
    logic rst;

    // 64-bit instance signals
    logic        aFlush, aInValid, aInReady, aJump, aMemEn, aWrite;
    logic [63:0] aPc, aAlu, aAddr, aWdata;
    logic [2:0]  aF3;
    logic        aOutValid;
    logic [63:0] aOutResult, aOutRdata;
    logic [1:0]  aOutExc;
    logic        aReq, aWe;
    logic [63:0] aDAddr, aDWdata;
    logic [7:0]  aDWstrb;
    logic        aGnt, aRvalid, aErr;
    logic [63:0] aRdata;

    // 32-bit instance signals
    logic        bFlush, bInValid, bInReady, bJump, bMemEn, bWrite;
    logic [63:0] bPc, bAddr;
    logic [31:0] bAlu, bWdata;
    logic [2:0]  bF3;
    logic        bOutValid;
    logic [31:0] bOutResult, bOutRdata;
    logic [1:0]  bOutExc;
    logic        bReq, bWe;
    logic [63:0] bDAddr;
    logic [31:0] bDWdata;
    logic [3:0]  bDWstrb;
    logic        bGnt, bRvalid, bErr;
    logic [31:0] bRdata;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          memEn;
        bit          write;
        bit          jump;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          err;
        int          gDly;
        int          rDly;
        int          expReqCyc;
        logic [63:0] expAddr;
        logic [7:0]  expStrb;
        logic [63:0] expWdata;
        logic [63:0] expRdata;
        logic [1:0]  expExc;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic [63:0] rdata;
        logic [1:0]  exc;
        int          lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sbQ[$];

    stage_mem_hs #(.XLEN(64), .ADDR_W(64), .TIMEOUT(8)) dutA (
        .clk_i(clk), .rst_i(rst), .flush_i(aFlush),
        .in_valid_i(aInValid), .in_ready_o(aInReady), .in_pc_i(aPc),
        .in_jump_i(aJump), .in_alu_out_i(aAlu), .in_mem_en_i(aMemEn),
        .in_mem_write_i(aWrite), .in_funct3_i(aF3), .in_addr_i(aAddr),
        .in_wdata_i(aWdata), .out_valid_o(aOutValid), .out_result_o(aOutResult),
        .out_rdata_o(aOutRdata), .out_exc_o(aOutExc), .dmem_req_o(aReq),
        .dmem_we_o(aWe), .dmem_addr_o(aDAddr), .dmem_wstrb_o(aDWstrb),
        .dmem_wdata_o(aDWdata), .dmem_gnt_i(aGnt), .dmem_rvalid_i(aRvalid),
        .dmem_err_i(aErr), .dmem_rdata_i(aRdata)
    );

    stage_mem_hs #(.XLEN(32), .ADDR_W(64), .TIMEOUT(16)) dutB (
        .clk_i(clk), .rst_i(rst), .flush_i(bFlush),
        .in_valid_i(bInValid), .in_ready_o(bInReady), .in_pc_i(bPc),
        .in_jump_i(bJump), .in_alu_out_i(bAlu), .in_mem_en_i(bMemEn),
        .in_mem_write_i(bWrite), .in_funct3_i(bF3), .in_addr_i(bAddr),
        .in_wdata_i(bWdata), .out_valid_o(bOutValid), .out_result_o(bOutResult),
        .out_rdata_o(bOutRdata), .out_exc_o(bOutExc), .dmem_req_o(bReq),
        .dmem_we_o(bWe), .dmem_addr_o(bDAddr), .dmem_wstrb_o(bDWstrb),
        .dmem_wdata_o(bDWdata), .dmem_gnt_i(bGnt), .dmem_rvalid_i(bRvalid),
        .dmem_err_i(bErr), .dmem_rdata_i(bRdata)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Compare one out_valid pulse of the 64-bit instance against the scoreboard head
    task automatic checkOutput(input int cyc);
        exp_t e;
        if (sbQ.size() == 0) begin
            check("unexpected out_valid", 64'(1), 64'(0));
        end else begin
            e = sbQ.pop_front();
            check("out_result", aOutResult, e.result);
            check("out_rdata", aOutRdata, e.rdata);
            check("out_exc", 64'(aOutExc), 64'(e.exc));
            check("latency", 64'(cyc), 64'(e.lat));
        end
    endtask

    // Issue one vector to the 64-bit instance and play the memory side
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   cyc;
        int   reqCyc;
        int   rvLeft;
        bit   done;
        @(negedge clk);
        aInValid = 1'b1; aMemEn = v.memEn; aWrite = v.write; aJump = v.jump;
        aF3 = v.f3; aAddr = v.addr; aPc = v.pc; aAlu = v.alu; aWdata = v.wdata;
        e.result = v.jump ? v.pc + 64'd4 : v.alu;
        e.rdata  = v.expRdata;
        e.exc    = v.expExc;
        e.lat    = v.expLat;
        sbQ.push_back(e);
        @(negedge clk);
        aInValid = 1'b0;
        cyc = 1; reqCyc = 0; rvLeft = -1; done = 1'b0;
        while (!done && cyc <= 60) begin
            aGnt = 1'b0; aRvalid = 1'b0; aErr = 1'b0; aRdata = '0;
            if (aOutValid) begin
                checkOutput(cyc);
                check("in_ready after result", 64'(aInReady), 64'(1));
                done = 1'b1;
            end else if (aReq) begin
                reqCyc++;
                if (reqCyc == 1) begin
                    check("dmem_addr", aDAddr, v.expAddr);
                    check("dmem_we", 64'(aWe), 64'(v.write));
                    if (v.write) begin
                        check("dmem_wstrb", 64'(aDWstrb), 64'(v.expStrb));
                        check("dmem_wdata", aDWdata, v.expWdata);
                    end
                end
                if (reqCyc == v.gDly + 1) begin
                    aGnt = 1'b1;
                    rvLeft = v.rDly;
                end
            end else if (rvLeft == 0) begin
                aRvalid = 1'b1; aRdata = v.rdata; aErr = v.err;
                rvLeft = -1;
            end else if (rvLeft > 0) begin
                rvLeft--;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("out_valid within budget", 64'(done), 64'(1));
        check("req cycles", 64'(reqCyc), 64'(v.expReqCyc));
    endtask

    // Present a load to the 64-bit instance for one cycle; returns at the first REQ cycle
    task automatic startA(input logic [2:0] f3, input logic [63:0] addr);
        @(negedge clk);
        aInValid = 1'b1; aMemEn = 1'b1; aWrite = 1'b0; aJump = 1'b0;
        aF3 = f3; aAddr = addr; aAlu = 64'h77;
        @(negedge clk);
        aInValid = 1'b0;
    endtask

    // One load on the 32-bit instance with immediate gnt/rvalid
    task automatic bTxn(input logic [2:0] f3, input logic [63:0] addr, input logic [31:0] rdata,
                        input int expReqCyc, input logic [63:0] expAddr, input logic [31:0] expRdata,
                        input logic [1:0] expExc, input int expLat);
        int cyc;
        int reqCyc;
        bit rvNext;
        bit done;
        @(negedge clk);
        bInValid = 1'b1; bMemEn = 1'b1; bWrite = 1'b0; bF3 = f3; bAddr = addr; bAlu = 32'h55;
        @(negedge clk);
        bInValid = 1'b0;
        cyc = 1; reqCyc = 0; rvNext = 1'b0; done = 1'b0;
        while (!done && cyc <= 20) begin
            bGnt = 1'b0; bRvalid = 1'b0; bRdata = '0;
            if (bOutValid) begin
                check("b out_rdata", 64'(bOutRdata), 64'(expRdata));
                check("b out_exc", 64'(bOutExc), 64'(expExc));
                check("b out_result", 64'(bOutResult), 64'h55);
                check("b latency", 64'(cyc), 64'(expLat));
                done = 1'b1;
            end else if (bReq) begin
                reqCyc++;
                check("b dmem_addr", bDAddr, expAddr);
                bGnt = 1'b1;
                rvNext = 1'b1;
            end else if (rvNext) begin
                bRvalid = 1'b1; bRdata = rdata;
                rvNext = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b out_valid within budget", 64'(done), 64'(1));
        check("b req cycles", 64'(reqCyc), 64'(expReqCyc));
    endtask

    // Main test sequence
    initial begin
        int badRdy;
        int badVal;
        rst = 1'b1;
        aFlush = 0; aInValid = 0; aJump = 0; aMemEn = 0; aWrite = 0; aPc = 0; aAlu = 0;
        aAddr = 0; aWdata = 0; aF3 = 0; aGnt = 0; aRvalid = 0; aErr = 0; aRdata = 0;
        bFlush = 0; bInValid = 0; bJump = 0; bMemEn = 0; bWrite = 0; bPc = 0; bAlu = 0;
        bAddr = 0; bWdata = 0; bF3 = 0; bGnt = 0; bRvalid = 0; bErr = 0; bRdata = 0;

        //          mem wr jmp f3      addr       pc        alu       wdata            rdata                    err g  r   rq  expAddr    strb    expWdata                 expRdata                 exc lat
        tbl.push_back('{1, 0, 0, 3'b010, 64'h1004, 64'h100, 64'h11,   64'h0,           64'h0000_0000_8000_0000, 0, 0,  0,  1, 64'h1000, 8'h00, 64'h0,                   64'h0,                   0, 3});
        tbl.push_back('{1, 0, 0, 3'b010, 64'h1000, 64'h100, 64'h12,   64'h0,           64'h0000_0000_8000_0000, 0, 0,  0,  1, 64'h1000, 8'h00, 64'h0,                   64'hFFFF_FFFF_8000_0000, 0, 3});
        tbl.push_back('{1, 1, 0, 3'b001, 64'h1006, 64'h104, 64'h22,   64'hBEEF,        64'h0,                   0, 3,  0,  4, 64'h1000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,                   0, 6});
        tbl.push_back('{1, 0, 0, 3'b001, 64'h1003, 64'h108, 64'h33,   64'h0,           64'h0,                   0, 0,  0,  0, 64'h0,    8'h00, 64'h0,                   64'h0,                   1, 1});
        tbl.push_back('{0, 0, 1, 3'b000, 64'h0,    64'h2000,64'h44,   64'h0,           64'h0,                   0, 0,  0,  0, 64'h0,    8'h00, 64'h0,                   64'h0,                   0, 1});
        tbl.push_back('{1, 0, 0, 3'b000, 64'h1002, 64'h10C, 64'h45,   64'h0,           64'h1122_3344_55F6_7788, 0, 1,  2,  2, 64'h1000, 8'h00, 64'h0,                   64'hFFFF_FFFF_FFFF_FFF6, 0, 6});
        tbl.push_back('{1, 0, 0, 3'b101, 64'h100A, 64'h110, 64'h46,   64'h0,           64'h1122_3344_55F6_7788, 0, 0,  0,  1, 64'h1008, 8'h00, 64'h0,                   64'h55F6,                0, 3});
        tbl.push_back('{1, 0, 0, 3'b110, 64'h1004, 64'h114, 64'h47,   64'h0,           64'h1122_3344_55F6_7788, 0, 0,  0,  1, 64'h1000, 8'h00, 64'h0,                   64'h1122_3344,           0, 3});
        tbl.push_back('{1, 0, 0, 3'b011, 64'h1008, 64'h118, 64'h48,   64'h0,           64'h1122_3344_55F6_7788, 0, 0,  0,  1, 64'h1008, 8'h00, 64'h0,                   64'h1122_3344_55F6_7788, 0, 3});
        tbl.push_back('{1, 1, 0, 3'b010, 64'h1004, 64'h11C, 64'h49,   64'h1234_5678,   64'h0,                   0, 0,  0,  1, 64'h1000, 8'hF0, 64'h1234_5678_0000_0000, 64'h0,                   0, 3});
        tbl.push_back('{1, 1, 0, 3'b000, 64'h1001, 64'h120, 64'h4A,   64'hAB,          64'h0,                   0, 0,  1,  1, 64'h1000, 8'h02, 64'hAB00,                64'h0,                   0, 4});
        tbl.push_back('{1, 1, 0, 3'b011, 64'h1004, 64'h124, 64'h4B,   64'h0,           64'h0,                   0, 0,  0,  0, 64'h0,    8'h00, 64'h0,                   64'h0,                   1, 1});
        tbl.push_back('{1, 0, 0, 3'b111, 64'h1000, 64'h128, 64'h4C,   64'h0,           64'h0,                   0, 0,  0,  0, 64'h0,    8'h00, 64'h0,                   64'h0,                   1, 1});
        tbl.push_back('{1, 0, 0, 3'b010, 64'h1000, 64'h12C, 64'h4D,   64'h0,           64'h5555_5555,           1, 0,  0,  1, 64'h1000, 8'h00, 64'h0,                   64'h0,                   2, 3});
        tbl.push_back('{1, 0, 0, 3'b010, 64'h1000, 64'h130, 64'h4E,   64'h0,           64'h0,                   0, 255,0,  8, 64'h1000, 8'h00, 64'h0,                   64'h0,                   3, 9});
        tbl.push_back('{1, 0, 0, 3'b010, 64'h1000, 64'h134, 64'h4F,   64'h0,           64'h0,                   0, 0, 255, 1, 64'h1000, 8'h00, 64'h0,                   64'h0,                   3, 10});
        tbl.push_back('{0, 0, 0, 3'b000, 64'h0,    64'h138, 64'hDEAD, 64'h0,           64'h0,                   0, 0,  0,  0, 64'h0,    8'h00, 64'h0,                   64'h0,                   0, 1});

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances
        check("reset out_valid", 64'(aOutValid), 64'(0));
        check("reset dmem_req", 64'(aReq), 64'(0));
        check("reset in_ready", 64'(aInReady), 64'(1));
        check("reset dmem_addr", aDAddr, 64'h0);
        check("reset out_exc", 64'(aOutExc), 64'(0));
        check("reset b dmem_req", 64'(bReq), 64'(0));

        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Flush during RESP: rvalid is absorbed, pipe stays stalled until then
        $display("[TB] flush in RESP");
        badRdy = 0; badVal = 0;
        startA(3'b000, 64'h7);
        check("flushResp req", 64'(aReq), 64'(1));
        check("flushResp addr", aDAddr, 64'h0);
        aGnt = 1'b1;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            if (aInReady) badRdy++;
            if (aOutValid) badVal++;
            aGnt = 1'b0;
            aFlush = (c == 3);
            aRvalid = (c == 7);
            aRdata = 64'hFF00_0000;
        end
        @(negedge clk);
        aRvalid = 1'b0;
        check("flushResp ready after absorb", 64'(aInReady), 64'(1));
        if (aOutValid) badVal++;
        @(negedge clk);
        if (aOutValid) badVal++;
        check("flushResp stalled cycles", 64'(badRdy), 64'(0));
        check("flushResp no out_valid", 64'(badVal), 64'(0));
        applyStimulus(tbl[4]);

        // Flush in REQ before gnt: request withdrawn, nothing reported
        $display("[TB] flush in REQ");
        startA(3'b010, 64'h2000);
        check("flushReq req", 64'(aReq), 64'(1));
        @(negedge clk);
        aFlush = 1'b1;
        @(negedge clk);
        aFlush = 1'b0;
        check("flushReq req dropped", 64'(aReq), 64'(0));
        check("flushReq ready", 64'(aInReady), 64'(1));
        check("flushReq no out_valid", 64'(aOutValid), 64'(0));
        @(negedge clk);
        check("flushReq no late out_valid", 64'(aOutValid), 64'(0));

        // Flush together with gnt: access issued, its rvalid absorbed
        $display("[TB] flush with gnt");
        startA(3'b010, 64'h3000);
        aGnt = 1'b1; aFlush = 1'b1;
        @(negedge clk);
        aGnt = 1'b0; aFlush = 1'b0;
        check("flushGnt waiting in RESP", 64'(aInReady), 64'(0));
        aRvalid = 1'b1;
        @(negedge clk);
        aRvalid = 1'b0;
        check("flushGnt no out_valid", 64'(aOutValid), 64'(0));
        check("flushGnt ready", 64'(aInReady), 64'(1));
        // A stray rvalid while idle must not produce a result
        aRvalid = 1'b1;
        @(negedge clk);
        aRvalid = 1'b0;
        @(negedge clk);
        check("stray rvalid ignored", 64'(aOutValid), 64'(0));

        // Reset in the middle of an access
        $display("[TB] reset mid-access");
        startA(3'b010, 64'h4000);
        check("midReset req before", 64'(aReq), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midReset req", 64'(aReq), 64'(0));
        check("midReset ready", 64'(aInReady), 64'(1));
        applyStimulus(tbl[16]);

        // 32-bit width
        $display("[TB] XLEN=32");
        bTxn(3'b100, 64'h3, 32'hF000_0000, 1, 64'h0, 32'hF0, 2'd0, 3);
        bTxn(3'b011, 64'h0, 32'h0,         0, 64'h0, 32'h0,  2'd1, 1);
        bTxn(3'b001, 64'h2, 32'h8001_0000, 1, 64'h0, 32'hFFFF_8001, 2'd0, 3);
        bTxn(3'b110, 64'h4, 32'h8000_0001, 1, 64'h4, 32'h8000_0001, 2'd0, 3);

        check("scoreboard drained", 64'(sbQ.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
